drum_tx_scheduler: RTL and testbench
====================================

// Module: drum_tx_scheduler
// PURPOSE
//  Shares the single SPI slave TX byte register between NUM_CH drum-trigger requesters.
//  - Latches per-channel trigger pulses as pending flags.
//  - Grants one channel per cycle, round-robin, and queues its 4-bit drum code in a small FIFO.
//  - Hands codes one at a time to the SPI TX path ({4'h0, code}) with a load/done handshake.
//  Sits between the drum-detection logic and the SPI slave shifter, in the clk domain.
// PARAMETERS
//  NUM_CH         4     number of trigger requesters; NUM_CH+CODE_BASE-1 <= 15
//  CODE_BASE      1     drum code sent for channel 0 (channel i -> CODE_BASE+i); code 0 = no event
//  FIFO_DEPTH     8     code queue depth, power of 2, >= 2
//  TIMEOUT_CYCLES 4096  max clk cycles in WAIT_DONE before the byte is abandoned
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  req          in   NUM_CH     one-cycle trigger pulse per channel
//  tx_done      in   1          one-cycle pulse, SPI byte shifted out (already synchronised to clk)
//  clear_err    in   1          one-cycle pulse, clears sticky error flags
//  tx_byte      out  8          byte presented to SPI TX buffer/shift reg
//  tx_load      out  1          one-cycle strobe: copy tx_byte into the SPI shift register
//  tx_busy      out  1          high in LOAD and WAIT_DONE
//  fifo_level   out  clog2(D)+1 current queue occupancy
//  drop_err     out  1          sticky: req arrived while that channel was already pending
//  timeout_err  out  1          sticky: WAIT_DONE timed out
// BEHAVIOUR
//  Reset values: all outputs 0, tx_byte=8'h00, pending=0, FIFO empty, rr pointer=0, state IDLE.
//  Pending capture:
//  - req[i]=1 sets pending[i].
//  - If pending[i] is already set and not being cleared that cycle, set drop_err; the event is merged.
//  Arbiter:
//  - Each cycle with any pending and a push allowed, grant the first pending channel at or after rr_ptr (wrapping).
//  - Clear its pending bit, push CODE_BASE+idx, and set rr_ptr=idx+1 mod NUM_CH.
//  - Push allowed = !full || pop-this-cycle.
//  - FIFO full: pending bits are held, no loss.
//  - req[i] in the same cycle as grant of i: set wins, pending[i] stays 1, no drop_err.
//  FSM states:
//  - IDLE: if FIFO not empty, pop and load tx_byte={4'h0,code} -> LOAD. Else tx_byte=8'h00.
//  - LOAD: tx_load=1 for exactly this cycle -> WAIT_DONE; clear timeout counter.
//  - WAIT_DONE: on tx_done -> IDLE. On counter==TIMEOUT_CYCLES-1, set timeout_err -> IDLE; the byte is discarded.
//  - tx_done outside WAIT_DONE is ignored.
//  tx_byte stays stable from LOAD until leaving WAIT_DONE.
//  Latency (idle, empty): req high in cycle n -> pending n+1 -> FIFO n+2 -> tx_load high in cycle n+3.
//  Back-to-back: the next tx_load comes 2 cycles after the tx_done cycle.
//  FIFO:
//  - Pointers carry an extra wrap bit; full when the MSBs differ and the rest match.
//  - Simultaneous push and pop at full or empty is legal; level is unchanged.
//  clear_err: clears both sticky flags; a new error in the same cycle wins.
//  Reset mid-operation: asynchronous to IDLE; the queue and pending bits are lost, tx_load drops immediately.
// STRUCTURE
//  Package drum_spi_pkg:
//  - DRUM_CODE_W=4, NO_EVENT=8'h00
//  - typedef enum {IDLE,LOAD,WAIT_DONE} tx_state_t
//  - function make_tx_byte(code) returning {4'h0,code}
//  Sub-module drum_event_fifo (parameterised width/depth sync FIFO with level output).
//  The arbiter and FSM stay in this module.
// TESTING
//  1. Single req[2] pulse with defaults -> tx_load 3 cycles later with tx_byte=8'h03; tx_done -> IDLE, tx_byte=8'h00.
//  2. req=4'b1111 in one cycle -> codes 1,2,3,4 in order; fifo_level peaks at 3; no drop_err.
//  3. rr_ptr=2, then req=4'b1011 -> grant order 3,0,1 (codes 4,1,2).
//  4. 12 staggered events with tx_done withheld:
//     - FIFO fills to 8, pending holds the rest, no codes lost;
//     - repeat req[0] while pending -> drop_err=1; clear_err -> 0.
//  5. No tx_done for 4096 cycles after tx_load -> timeout_err=1, state IDLE, next queued code loads.
//  6. Assert rst_n low in WAIT_DONE with 3 codes queued -> all outputs 0 at once; after release, no tx_load without new req.

Source files
------------

// File: rtl/drum_spi_pkg.sv
// Shared types and helpers for the drum-trigger to SPI TX byte path.
package drum_spi_pkg;

  localparam int         DRUM_CODE_W = 4;
  localparam logic [7:0] NO_EVENT    = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE
  } tx_state_t;

  function automatic logic [7:0] make_tx_byte(input logic [DRUM_CODE_W-1:0] code);
    return {4'h0, code};
  endfunction

endpackage

// File: rtl/drum_event_fifo.sv
// Purpose: generic synchronous FIFO with occupancy output.
// Latency: a pushed entry is readable on pop_dat_o the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module drum_event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_rdy_i,
  output logic [W-1:0]             pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  // The extra pointer MSB tells a full queue apart from an empty one.
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop    = pop_rdy_i && !empty_o;
  assign do_push   = push_vld_i && (!full_o || do_pop);
  assign level_o   = wr_q - rd_q;
  assign pop_dat_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/drum_tx_scheduler.sv
// Purpose: round-robin arbitration of drum trigger channels onto one SPI TX byte register.
// Latency: req in cycle n -> tx_load in cycle n+3 when idle; next load 2 cycles after tx_done.
// Backpressure: full queue holds requests as pending flags; a repeat while pending is merged.
module drum_tx_scheduler
  import drum_spi_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CODE_BASE      = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             req,
  input  logic                          tx_done,
  input  logic                          clear_err,
  output logic [7:0]                    tx_byte,
  output logic                          tx_load,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_err,
  output logic                          timeout_err
);

  localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  tx_state_t              state_q;
  logic [7:0]             tx_byte_q;
  logic                   tx_load_q;
  logic                   timeout_err_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_CH-1:0]      pending_q, pending_d, gnt_vec;
  logic [RW-1:0]          rr_q, rr_d, gnt_idx;
  logic [RW:0]            cand;
  logic                   drop_err_q, drop_err_d;
  logic                   gnt_found, push, pop, fifo_full, fifo_empty;
  logic [DRUM_CODE_W-1:0] push_code, pop_code;

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign push      = gnt_found && (!fifo_full || pop);
  assign push_code = DRUM_CODE_W'(CODE_BASE) + DRUM_CODE_W'(gnt_idx);

  always_comb begin
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_q} + (RW+1)'(k);
      if (cand >= (RW+1)'(NUM_CH)) cand = cand - (RW+1)'(NUM_CH);
      if (!gnt_found && pending_q[cand[RW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[RW-1:0];
      end
    end
    if (push) gnt_vec[gnt_idx] = 1'b1;
    // A fresh request on the channel being granted re-arms it without counting as a drop.
    pending_d  = (pending_q & ~gnt_vec) | req;
    drop_err_d = (drop_err_q & ~clear_err) | (|(req & pending_q & ~gnt_vec));
    rr_d       = rr_q;
    if (push) rr_d = (gnt_idx == RW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_q       <= '0;
      drop_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      drop_err_q <= drop_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_byte_q     <= NO_EVENT;
      tx_load_q     <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      if (clear_err) timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_byte_q <= make_tx_byte(pop_code);
            tx_load_q <= 1'b1;
            state_q   <= LOAD;
          end else begin
            tx_byte_q <= NO_EVENT;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state_q   <= IDLE;
            tx_byte_q <= NO_EVENT;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
            tx_byte_q     <= NO_EVENT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  drum_event_fifo #(
    .W     (DRUM_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (push),
    .push_dat_i (push_code),
    .pop_rdy_i  (pop),
    .pop_dat_o  (pop_code),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign tx_byte     = tx_byte_q;
  assign tx_load     = tx_load_q;
  assign tx_busy     = (state_q != IDLE);
  assign drop_err    = drop_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_drum_tx_scheduler.sv
// Directed and random stimulus against a queue-based reference model of the drum TX scheduler.
module tb_drum_tx_scheduler;

  localparam int NUM_CH = 4, CODE_BASE = 1, FIFO_DEPTH = 8, TIMEOUT_CYCLES = 4096;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] req = '0;
  logic              tx_done = 1'b0;
  logic              clear_err = 1'b0;
  logic [7:0]        tx_byte;
  logic              tx_load, tx_busy, drop_err, timeout_err;
  logic [LW-1:0]     fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drum_tx_scheduler #(
    .NUM_CH(NUM_CH), .CODE_BASE(CODE_BASE), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tx_done(tx_done), .clear_err(clear_err),
    .tx_byte(tx_byte), .tx_load(tx_load), .tx_busy(tx_busy), .fifo_level(fifo_level),
    .drop_err(drop_err), .timeout_err(timeout_err)
  );

  // Reference model: 0 = idle, 1 = loading, 2 = waiting for the shifter.
  bit         m_pend [NUM_CH];
  int         m_rr, m_st, m_cnt;
  int         m_q [$];
  logic [7:0] m_cur;
  bit         m_load, m_drop, m_tout;
  int         sent [$];
  int         peak;
  int         n;
  int         code_cnt [16];
  logic [NUM_CH-1:0] rnd_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_rr = 0; m_st = 0; m_cnt = 0; m_cur = 8'h00;
    m_load = 0; m_drop = 0; m_tout = 0;
    m_q.delete();
  endtask

  function automatic bit any_pend();
    bit a = 0;
    foreach (m_pend[i]) a |= m_pend[i];
    return a;
  endfunction

  task automatic model_step(input logic [NUM_CH-1:0] r, input logic d, input logic c);
    bit pop, nd, nt;
    int g, idx;
    pop = (m_st == 0) && (m_q.size() != 0);
    g = -1;
    if (m_q.size() < FIFO_DEPTH || pop)
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (m_rr + k) % NUM_CH;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    nd = 0;
    for (int i = 0; i < NUM_CH; i++) if (r[i] && m_pend[i] && i != g) nd = 1;
    nt = 0;
    case (m_st)
      0: if (pop) begin m_cur = 8'(m_q.pop_front()); m_st = 1; end else m_cur = 8'h00;
      1: begin m_st = 2; m_cnt = 0; end
      default: begin
        if (d) begin m_st = 0; m_cur = 8'h00; end
        else if (m_cnt == TIMEOUT_CYCLES - 1) begin nt = 1; m_st = 0; m_cur = 8'h00; end
        else m_cnt++;
      end
    endcase
    if (g >= 0) begin
      m_q.push_back(CODE_BASE + g);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % NUM_CH;
    end
    for (int i = 0; i < NUM_CH; i++) if (r[i]) m_pend[i] = 1'b1;
    m_drop = (m_drop && !c) || nd;
    m_tout = (m_tout && !c) || nt;
    m_load = (m_st == 1);
  endtask

  task automatic tick(input logic [NUM_CH-1:0] r, input logic d, input logic c);
    req = r; tx_done = d; clear_err = c;
    @(posedge clk);
    model_step(r, d, c);
    #1;
    req = '0; tx_done = 1'b0; clear_err = 1'b0;
    chk("tx_load", tx_load, m_load);
    chk("tx_byte", tx_byte, m_cur);
    chk("tx_busy", tx_busy, m_st != 0);
    chk("fifo_level", fifo_level, m_q.size());
    chk("drop_err", drop_err, m_drop);
    chk("timeout_err", timeout_err, m_tout);
    if (tx_load) sent.push_back(int'(tx_byte));
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic serve(input int budget);
    int k = 0;
    bit idle = 0;
    while (!idle && k < budget) begin
      tick('0, (m_st == 2) && ($urandom_range(0, 2) == 0), 1'b0);
      k++;
      idle = (m_st == 0) && (m_q.size() == 0) && !any_pend();
    end
    chk("serve_drained", idle, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    sent.delete(); peak = 0;
  endtask

  initial begin
    int exp2 [4] = '{1, 2, 3, 4};
    int exp3 [3] = '{4, 1, 2};
    model_reset();
    peak = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_errs", {drop_err, timeout_err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single request on channel 2: load three cycles later, byte 0x03.
    tick(4'b0100, 0, 0);
    tick('0, 0, 0);
    chk("t1_noload_early", tx_load, 0);
    tick('0, 0, 0);
    chk("t1_load", tx_load, 1);
    chk("t1_byte", tx_byte, 8'h03);
    tick('0, 0, 0);
    tick('0, 1, 0);
    chk("t1_idle_byte", tx_byte, 8'h00);
    chk("t1_idle_busy", tx_busy, 0);

    // All channels at once from rr=0.
    do_reset();
    tick(4'b1111, 0, 0);
    serve(200);
    chk("t2_count", sent.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_code", sent[i], exp2[i]);
    chk("t2_peak", peak, 3);
    chk("t2_drop", drop_err, 0);

    // Grant channel 1 first so the pointer sits at 2.
    do_reset();
    tick(4'b0010, 0, 0);
    serve(200);
    sent.delete();
    tick(4'b1011, 0, 0);
    serve(200);
    chk("t3_count", sent.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_code", sent[i], exp3[i]);

    // Twelve staggered events with the shifter stalled.
    sent.delete(); peak = 0;
    for (int e = 0; e < 12; e++) tick(NUM_CH'(1 << (e % NUM_CH)), 0, 0);
    repeat (3) tick('0, 0, 0);
    chk("t4_full", fifo_level, FIFO_DEPTH);
    chk("t4_nodrop", drop_err, 0);
    tick(4'b0001, 0, 0);
    tick(4'b0001, 0, 0);
    chk("t4_drop", drop_err, 1);
    tick('0, 0, 1);
    chk("t4_clear", drop_err, 0);
    serve(600);
    chk("t4_count", sent.size(), 13);
    foreach (code_cnt[i]) code_cnt[i] = 0;
    foreach (sent[i]) code_cnt[sent[i] & 15]++;
    chk("t4_code1", code_cnt[1], 4);
    chk("t4_code2", code_cnt[2], 3);
    chk("t4_code3", code_cnt[3], 3);
    chk("t4_code4", code_cnt[4], 3);

    // Shifter never answers: the byte is abandoned after the timeout.
    tick(4'b0100, 0, 0);
    tick(4'b0001, 0, 0);
    tick('0, 0, 0);
    chk("t5_load", tx_load, 1);
    chk("t5_byte", tx_byte, 8'h03);
    repeat (TIMEOUT_CYCLES) tick('0, 0, 0);
    chk("t5_still_wait", tx_busy, 1);
    chk("t5_no_tout_yet", timeout_err, 0);
    tick('0, 0, 0);
    chk("t5_tout", timeout_err, 1);
    chk("t5_idle", tx_busy, 0);
    chk("t5_byte_cleared", tx_byte, 8'h00);
    tick('0, 0, 0);
    chk("t5_next_load", tx_load, 1);
    chk("t5_next_byte", tx_byte, 8'h01);
    tick('0, 1, 1);
    chk("t5_done_in_load_ignored", tx_busy, 1);
    chk("t5_clear", timeout_err, 0);
    serve(200);

    // Reset while waiting with three codes queued.
    tick(4'b1111, 0, 0);
    n = 0;
    while (!(m_st == 2 && m_q.size() == 3) && n < 20) begin
      tick('0, 0, 0);
      n++;
    end
    chk("t6_reached", (m_st == 2) && (m_q.size() == 3), 1);
    chk("t6_level_before", fifo_level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_load", tx_load, 0);
    chk("t6_tx_busy", tx_busy, 0);
    chk("t6_tx_byte", tx_byte, 8'h00);
    chk("t6_level", fifo_level, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    sent.delete();
    repeat (10) tick('0, 0, 0);
    chk("t6_no_load", sent.size(), 0);

    // Random traffic, including stray tx_done pulses and clears.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NUM_CH; b++) rnd_req[b] = ($urandom_range(0, 7) == 0);
      tick(rnd_req, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end
    serve(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
